// File: rtl/mux_sequencer_pkg.sv
// Shared constants for the mux sequencer: Mux select codes (src_mask bit i maps to
// code i) and the settle counter width.
package mux_sequencer_pkg;

  localparam int unsigned MUX_SEL_COUNTER_CARRY  = 0;
  localparam int unsigned MUX_SEL_COUNTER_VALUE  = 1;
  localparam int unsigned MUX_SEL_REGISTER_2_MSB = 2;
  localparam int unsigned MUX_SEL_REGISTER_2_LSB = 3;

  // SETTLE_CYCLES is limited to 1..15
  localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/mux_priority_next.sv
// Combinational search: lowest set mask bit above idx (or at idx when inclusive),
// with a flag when no such bit exists.
module mux_priority_next
  import mux_sequencer_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic [(2**SEL_WIDTH)-1:0] mask,
  input  logic [SEL_WIDTH-1:0]      idx,
  input  logic                      inclusive,
  output logic [SEL_WIDTH-1:0]      nxt,
  output logic                      none
);

  localparam int unsigned NSRC = 2**SEL_WIDTH;

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (mask[i-1] && (((i - 1) > 32'(idx)) || (inclusive && ((i - 1) == 32'(idx))))) begin
        nxt  = SEL_WIDTH'(i - 1);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_sequencer.sv
// Steps the Mux select through a masked source list and hands each byte downstream
// on valid/ready. Define MUX_SEQUENCER_REPEAT_EN to add repeat_mode (continuous passes).
module mux_sequencer
  import mux_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SEL_WIDTH     = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
`ifdef MUX_SEQUENCER_REPEAT_EN
  input  logic                      repeat_mode,
`endif
  input  logic                      start,
  input  logic                      abort,
  input  logic [(2**SEL_WIDTH)-1:0] src_mask,
  output logic [SEL_WIDTH-1:0]      mux_sel,
  input  logic [DATA_WIDTH-1:0]     mux_data,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0]      out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned NSRC = 2**SEL_WIDTH;

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, FINISH} state_e;

  state_e                  state_q, state_d;
  logic [NSRC-1:0]         mask_q, mask_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]    osel_q, osel_d;
  logic                    valid_q, valid_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    rep_q, rep_d;

  logic [NSRC-1:0]         pn_mask;
  logic [SEL_WIDTH-1:0]    pn_idx;
  logic                    pn_incl;
  logic [SEL_WIDTH-1:0]    pn_nxt;
  logic                    pn_none;

  // PRESENT looks for the next bit of the latched mask; otherwise the first bit of the live mask.
  always_comb begin
    pn_mask = (state_q == PRESENT) ? mask_q : src_mask;
    pn_idx  = (state_q == PRESENT) ? sel_q : '0;
    pn_incl = (state_q != PRESENT);
  end

  mux_priority_next #(.SEL_WIDTH(SEL_WIDTH)) u_next (
    .mask      (pn_mask),
    .idx       (pn_idx),
    .inclusive (pn_incl),
    .nxt       (pn_nxt),
    .none      (pn_none)
  );

  // The first source of a pass gets one extra settle edge (counter preloaded with
  // SETTLE_CYCLES rather than SETTLE_CYCLES-1), giving start-to-valid of 1+SETTLE_CYCLES.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    data_d  = data_q;
    osel_d  = osel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = src_mask;
          if (pn_none) begin
            state_d = FINISH;
          end else begin
            sel_d   = pn_nxt;
            cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES);
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          data_d  = mux_data;
          osel_d  = sel_q;
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PRESENT: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (!pn_none) begin
            sel_d   = pn_nxt;
            cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
          end else begin
`ifdef MUX_SEQUENCER_REPEAT_EN
            rep_d   = repeat_mode;
`endif
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (rep_q) begin
          mask_d = src_mask;
          rep_d  = 1'b0;
          if (!pn_none) begin
            sel_d   = pn_nxt;
            cnt_d   = SETTLE_CNT_W'(SETTLE_CYCLES);
            state_d = SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      osel_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      osel_q  <= osel_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  assign mux_sel   = sel_q;
  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign out_valid = valid_q;
  assign done      = (state_q == FINISH);
  assign busy      = (state_q == SETTLE) || (state_q == PRESENT) || ((state_q == FINISH) && rep_q);

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed + randomized bench for mux_sequencer (default build, SETTLE_CYCLES=1)
// against a queue-based model of the visiting order and handshake timing.
module tb_mux_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] src_mask;
  logic [1:0] mux_sel;
  logic [7:0] mux_data;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  mux_sequencer #(.DATA_WIDTH(8), .SEL_WIDTH(2), .SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .src_mask  (src_mask),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_val(input int s);
    case (s)
      0:       return 8'h01;
      1:       return 8'haa;
      2:       return 8'hbe;
      default: return 8'hef;
    endcase
  endfunction

  // Mux model: carry=1, value=aa, msb=be, lsb=ef
  assign mux_data = src_val(int'(mux_sel));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Runs one sequence, checking bytes, order, latency, stall stability and done.
  task automatic run_seq(input logic [3:0] mask, input int stall, input bit rnd, input bit poke);
    logic [7:0] eb[$];
    logic [1:0] es[$];
    int n, hold, first_n, acc_n, dones, nbytes, exp_n;
    bit prev_valid, busy_seen;
    logic [7:0] held_d;
    logic [1:0] held_s;
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        eb.push_back(src_val(i));
        es.push_back(2'(i));
      end
    exp_n = eb.size();
    start = 1'b1; src_mask = mask; out_ready = 1'b0;
    n = 0; hold = 0; first_n = -1; acc_n = -1; dones = 0; nbytes = 0;
    prev_valid = 1'b0; busy_seen = 1'b0; held_d = '0; held_s = '0;
    while (n < 300 && dones == 0) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) src_mask = 4'($urandom);
      if (poke && n == 4) start = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        dones++;
        chk("done_busy_low", busy, 0);
        chk("done_latency", n, (exp_n == 0) ? 1 : acc_n + 1);
      end
      if (out_valid) begin
        if (!prev_valid) begin
          if (first_n < 0) begin
            chk("first_latency", n, 3);
            first_n = n;
          end else begin
            chk("next_latency", n, acc_n + 2);
          end
          nbytes++;
          held_d = out_data;
          held_s = out_sel;
          if (eb.size() > 0) begin
            chk("out_data", out_data, eb.pop_front());
            chk("out_sel", out_sel, es.pop_front());
          end
          hold = rnd ? int'($urandom_range(0, stall)) : stall;
        end else begin
          chk("stall_data", out_data, held_d);
          chk("stall_sel", out_sel, held_s);
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'b1;
          acc_n = n;
        end
      end else begin
        out_ready = 1'($urandom);
      end
      prev_valid = out_valid;
    end
    chk("done_count", dones, 1);
    chk("byte_count", nbytes, exp_n);
    chk("busy_seen", busy_seen, (exp_n != 0));
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_done", done, 0);
    chk("after_valid", out_valid, 0);
  endtask

  task automatic run_abort();
    int rises;
    bit found, prev;
    start = 1'b1; src_mask = 4'hf; out_ready = 1'b1;
    rises = 0; found = 1'b0; prev = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && !prev) rises++;
      prev = out_valid;
      if (out_valid && rises == 2) begin
        found = 1'b1;
        chk("abort_byte", out_data, 8'haa);
        abort = 1'b1;
      end
    end
    chk("abort_reached", found, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sel_kept", mux_sel, 1);
    for (int n = 0; n < 3; n++) begin
      chk("abort_no_done", done, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; src_mask = '0; out_ready = 1'b0;
    #2;
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_seq(4'b1111, 0, 1'b0, 1'b1);
    run_seq(4'b1010, 3, 1'b0, 1'b0);
    run_seq(4'b0000, 0, 1'b0, 1'b0);
    run_abort();
    run_seq(4'b1111, 0, 1'b0, 1'b0);

    // reset mid-SETTLE
    start = 1'b1; src_mask = 4'hf;
    @(negedge clk);
    start = 1'b0;
    chk("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mux_sel", mux_sel, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("mid_rst_no_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 10; r++)
      run_seq(4'($urandom_range(0, 15)), 3, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
